maze_position_tracker: RTL and testbench
========================================

# maze_position_tracker

Owns the player's committed maze position. Consumes the `next_count` proposals from the button handler and returns the registered `count` that the handler adds to or subtracts from. Validates each proposal against the 18-wide, 198-cell maze bitmap and runs the play/crash/win/game-over state machine. Also tracks lives and move totals for the display and scoring logic.

## Interface
- `GRID_W`, 18, maze row width in cells
- `CELLS`, 198, number of valid cells; indices 0..CELLS-1
- `START_LIVES`, 3, lives loaded at reset; range 1..3
- `CRASH_HOLD`, 10, number of `step_valid` strobes spent in CRASH before returning to IDLE
- `CLK` input 1: single system clock.
- `RST` input 1: synchronous, active-high reset.
- `step_valid` input 1: one-cycle strobe, high the cycle after the handler updates `next_count` (5 Hz rate).
- `next_count` input 8: proposed cell index. 255 means wall hit or no position.
- `mazestate` input 198: bit i = 1 means cell i is open; 0 means wall.
- `begin_spot` input 8: start cell.
- `end_spot` input 8: goal cell.
- `game_pause` input 1: freezes all state while high.
- `count` output 8: committed position; 255 when off-maze.
- `lives` output 2: remaining lives.
- `move_total` output 10: accepted moves since the last start.
- `game_state` output 2: 0 IDLE, 1 PLAY, 2 CRASH, 3 END.
- `won` output 1: in END, 1 = goal reached, 0 = out of lives.
- `crash_pulse` output 1: one-cycle pulse on a crash.
- `win_pulse` output 1: one-cycle pulse on reaching the goal.

## Operation
- **Event rule.** An event is `step_valid` high with `game_pause` low, sampled on a rising `CLK`. No state changes without an event, except that pulses return to 0.
- **IDLE.**
  - `count` = 255.
  - On an event where `next_count` == `begin_spot`, `begin_spot` < `CELLS`, and `mazestate[begin_spot]` == 1: go to PLAY, set `count` = `begin_spot`, set `move_total` = 0.
  - All other events are ignored.
- **PLAY.** Each event is checked in this priority order:
  1. **Crash.** `next_count` == 255, or `next_count` ≥ `CELLS`, or `mazestate[next_count]` == 0.
     - `count` = 255, `crash_pulse` = 1, `lives` decrements.
     - If `lives` becomes 0: go to END with `won` = 0. Otherwise go to CRASH with the hold counter cleared.
  2. **No move.** `next_count` == `count`: nothing changes.
  3. **Illegal jump.** The proposal is not an orthogonal neighbour: not ±`GRID_W`, and not ±1 within the same row.
     - Left is legal only if `count` % `GRID_W` != 0.
     - Right is legal only if `count` % `GRID_W` != `GRID_W`-1.
     - The proposal is ignored and `count` holds. Lives are not deducted.
  4. **Accepted move.** `count` = `next_count`, and `move_total` increments (saturates at 1023).
     - If `next_count` == `end_spot`: go to END, set `won` = 1, `win_pulse` = 1.
- **CRASH.**
  - `count` = 255.
  - Each event increments the hold counter. When it reaches `CRASH_HOLD`, go to IDLE. The transition happens on that same event; proposals during CRASH are not evaluated.
- **END.** Terminal. `count` keeps its last value and all events are ignored until `RST`.
- **Arithmetic.**
  - Neighbour checks compare zero-extended 9-bit values, so handler underflow (e.g. 5-18 wraps to 243) never aliases to a neighbour.
  - Row and column come from divide/modulo by the constant `GRID_W`; a combinational divide is acceptable.

## Timing
- **Reset.** `RST` takes priority over everything. Reset values:
  - `count` = 255, `lives` = `START_LIVES`, `move_total` = 0, `game_state` = 0
  - `won` = 0, `crash_pulse` = 0, `win_pulse` = 0, hold counter = 0
- **Reset mid-game.** Reset in any state returns to these values on the next edge.
- **Latency.** All outputs are registered. The effect of an event is visible the cycle after the sampling edge.
- **Pulses.** `crash_pulse` and `win_pulse` are high for exactly one `CLK` cycle.
- **Pause.** `step_valid` coincident with `game_pause` high is discarded entirely, not deferred. The CRASH hold count freezes.
- **Repeated strobes.** Back-to-back `step_valid` cycles are each treated as a separate event.
- **Loop behaviour.** `count` feeds back to the handler. A rejected (illegal-jump) proposal leaves `count` unchanged, so the handler's next proposal is relative to the held position.

## Configuration
- **`TRACKER_MOVE_COUNT_EN`**, defined: `move_total` behaves as described above.
- **`TRACKER_MOVE_COUNT_EN`**, undefined: the counter is not instantiated and `move_total` is constant 0. All other behaviour is identical.

## Test plan
- **Start then move.** `begin_spot`=181 open, event with `next_count`=181, then event with `next_count`=163 (open) → `game_state`=1, `count`=181 then 163, `move_total`=1.
- **Crashes to game over.** From PLAY, three wall crashes with `next_count`=255, each followed by 10 CRASH events and a restart → `lives` 2, 1, 0; `crash_pulse` three times; after the third, `game_state`=3, `won`=0, `count`=255.
- **Row-wrap rejection.** `count`=35 (column 17), `next_count`=36 → `count` stays 35, `lives` unchanged, no pulse.
- **Pause.** `game_pause`=1 with `step_valid` and `next_count`=255 in PLAY → no crash, `count` unchanged. After release, the same event crashes.
- **Win.** `end_spot`=20, move from 38 to 20 → `win_pulse` for 1 cycle, `game_state`=3, `won`=1. Later events leave `count`=20.
- **Reset mid-CRASH.** Assert `RST` at hold count 5 → next cycle: `game_state`=0, `lives`=3, `move_total`=0.

Source files
------------

// File: rtl/maze_position_tracker_if.sv
// Handler <-> position tracker bus: proposals and maze data in, committed position and game status out.
interface maze_position_tracker_if #(
  parameter int CELLS = 198
);
  logic             step_valid;
  logic [7:0]       next_count;
  logic [CELLS-1:0] mazestate;
  logic [7:0]       begin_spot;
  logic [7:0]       end_spot;
  logic             game_pause;
  logic [7:0]       count;
  logic [1:0]       lives;
  logic [9:0]       move_total;
  logic [1:0]       game_state;
  logic             won;
  logic             crash_pulse;
  logic             win_pulse;

  modport master (
    output step_valid, next_count, mazestate, begin_spot, end_spot, game_pause,
    input  count, lives, move_total, game_state, won, crash_pulse, win_pulse
  );

  modport slave (
    input  step_valid, next_count, mazestate, begin_spot, end_spot, game_pause,
    output count, lives, move_total, game_state, won, crash_pulse, win_pulse
  );
endinterface

// File: rtl/maze_position_tracker.sv
// Validates handler proposals against the maze bitmap and runs the play/crash/win/game-over FSM.
// Optional macro TRACKER_MOVE_COUNT_EN enables the accepted-move counter (move_total is 0 otherwise).
module maze_position_tracker #(
  parameter int GRID_W      = 18,
  parameter int CELLS       = 198,
  parameter int START_LIVES = 3,
  parameter int CRASH_HOLD  = 10
) (
  input logic                    CLK,
  input logic                    RST,
  maze_position_tracker_if.slave bus
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PLAY  = 2'd1;
  localparam logic [1:0] S_CRASH = 2'd2;
  localparam logic [1:0] S_END   = 2'd3;

  localparam int              HOLD_W   = $clog2(CRASH_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(CRASH_HOLD);
  localparam logic [8:0]      GW9      = 9'(GRID_W);
  localparam logic [8:0]      CELLS9   = 9'(CELLS);
  localparam logic [7:0]      OFF_MAZE = 8'd255;

  logic [1:0]        state;
  logic [7:0]        count_r;
  logic [1:0]        lives_r;
  logic              won_r;
  logic [HOLD_W-1:0] hold_r;
  logic              crash_p;
  logic              win_p;
  logic              event_v;

  function automatic logic cell_open(input logic [7:0] idx, input logic [CELLS-1:0] maze);
    logic [CELLS-1:0] sh;
    sh = maze >> idx;
    return ({1'b0, idx} < CELLS9) && sh[0];
  endfunction

  // 9-bit zero-extended compares so a wrapped handler subtraction never looks adjacent.
  function automatic logic is_neighbour(input logic [7:0] cur, input logic [7:0] nxt);
    logic [8:0] c9, n9, col;
    c9  = {1'b0, cur};
    n9  = {1'b0, nxt};
    col = c9 % GW9;
    return (n9 + GW9 == c9) || (n9 == c9 + GW9) ||
           ((n9 + 9'd1 == c9) && (col != 9'd0)) ||
           ((n9 == c9 + 9'd1) && (col != GW9 - 9'd1));
  endfunction

  assign event_v = bus.step_valid && !bus.game_pause;

`ifdef TRACKER_MOVE_COUNT_EN
  logic [9:0] moves_r;

  always_ff @(posedge CLK) begin
    if (RST) begin
      moves_r <= '0;
    end else if (event_v) begin
      if (state == S_IDLE && bus.next_count == bus.begin_spot && cell_open(bus.begin_spot, bus.mazestate))
        moves_r <= '0;
      else if (state == S_PLAY && cell_open(bus.next_count, bus.mazestate) &&
               bus.next_count != count_r && is_neighbour(count_r, bus.next_count) &&
               moves_r != 10'h3FF)
        moves_r <= moves_r + 10'd1;
    end
  end

  assign bus.move_total = moves_r;
`else
  assign bus.move_total = '0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= S_IDLE;
      count_r <= OFF_MAZE;
      lives_r <= 2'(START_LIVES);
      won_r   <= 1'b0;
      hold_r  <= '0;
      crash_p <= 1'b0;
      win_p   <= 1'b0;
    end else begin
      crash_p <= 1'b0;
      win_p   <= 1'b0;
      if (event_v) begin
        case (state)
          S_IDLE: begin
            if (bus.next_count == bus.begin_spot && cell_open(bus.begin_spot, bus.mazestate)) begin
              state   <= S_PLAY;
              count_r <= bus.begin_spot;
            end
          end
          S_PLAY: begin
            if (!cell_open(bus.next_count, bus.mazestate)) begin
              count_r <= OFF_MAZE;
              crash_p <= 1'b1;
              lives_r <= lives_r - 2'd1;
              hold_r  <= '0;
              state   <= (lives_r == 2'd1) ? S_END : S_CRASH;
              won_r   <= 1'b0;
            end else if (bus.next_count != count_r && is_neighbour(count_r, bus.next_count)) begin
              count_r <= bus.next_count;
              if (bus.next_count == bus.end_spot) begin
                state <= S_END;
                won_r <= 1'b1;
                win_p <= 1'b1;
              end
            end
          end
          S_CRASH: begin
            if (hold_r + HOLD_W'(1) == HOLD_MAX) begin
              state  <= S_IDLE;
              hold_r <= '0;
            end else begin
              hold_r <= hold_r + HOLD_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.count       = count_r;
  assign bus.lives       = lives_r;
  assign bus.game_state  = state;
  assign bus.won         = won_r;
  assign bus.crash_pulse = crash_p;
  assign bus.win_pulse   = win_p;
endmodule

// File: tb/tb_maze_position_tracker.sv
// Directed bench for maze_position_tracker: row/column reference model checked every cycle plus literal pins.
module tb_maze_position_tracker;
  localparam int W = 18;
  localparam int N = 198;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  maze_position_tracker_if #(.CELLS(N)) bus ();

  maze_position_tracker #(
    .GRID_W(W), .CELLS(N), .START_LIVES(3), .CRASH_HOLD(10)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  typedef struct packed {
    logic [1:0] st;
    logic [7:0] cnt;
    logic [1:0] lives;
    logic [9:0] moves;
    logic       won;
    logic [7:0] hold;
    logic       cp;
    logic       wp;
  } model_t;

  model_t mdl;
  logic   mdl_valid = 1'b0;
  int     tests = 0;
  int     fails = 0;

  function automatic model_t next_model(input model_t m, input logic rst, input logic sv,
                                        input logic pause, input logic [7:0] nc,
                                        input logic [N-1:0] maze, input logic [7:0] bs,
                                        input logic [7:0] es);
    model_t r;
    int n, c;
    bit adj;
    r = m;
    r.cp = 1'b0;
    r.wp = 1'b0;
    n = int'(nc);
    c = int'(m.cnt);
    if (rst) begin
      r = '0;
      r.cnt = 8'd255;
      r.lives = 2'd3;
    end else if (sv && !pause) begin
      if (m.st == 2'd0) begin
        if (nc == bs && int'(bs) < N && maze[bs] == 1'b1) begin
          r.st = 2'd1; r.cnt = bs; r.moves = '0;
        end
      end else if (m.st == 2'd1) begin
        if (n >= N || maze[n] == 1'b0) begin
          r.cnt = 8'd255; r.cp = 1'b1; r.lives = m.lives - 2'd1; r.hold = '0;
          if (m.lives == 2'd1) begin r.st = 2'd3; r.won = 1'b0; end
          else r.st = 2'd2;
        end else if (n != c) begin
          adj = ((n / W == c / W) && (n - c == 1 || c - n == 1)) ||
                ((n % W == c % W) && (n - c == W || c - n == W));
          if (adj) begin
            r.cnt = nc;
`ifdef TRACKER_MOVE_COUNT_EN
            if (m.moves != 10'h3FF) r.moves = m.moves + 10'd1;
`endif
            if (nc == es) begin r.st = 2'd3; r.won = 1'b1; r.wp = 1'b1; end
          end
        end
      end else if (m.st == 2'd2) begin
        r.hold = m.hold + 8'd1;
        if (int'(r.hold) == 10) begin r.st = 2'd0; r.hold = '0; end
      end
    end
    return r;
  endfunction

  always @(posedge CLK) begin
    mdl <= next_model(mdl, RST, bus.step_valid, bus.game_pause, bus.next_count,
                      bus.mazestate, bus.begin_spot, bus.end_spot);
    if (RST) mdl_valid <= 1'b1;
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic [7:0] n);
    @(posedge CLK); #1;
    bus.step_valid = 1'b1;
    bus.next_count = n;
    @(posedge CLK); #1;
    bus.step_valid = 1'b0;
  endtask

  task automatic burst(input int k);
    @(posedge CLK); #1;
    bus.step_valid = 1'b1;
    bus.next_count = 8'd0;
    repeat (k) @(posedge CLK);
    #1;
    bus.step_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
  endtask

  initial begin
    int exp_mv;
`ifdef TRACKER_MOVE_COUNT_EN
    exp_mv = 1;
`else
    exp_mv = 0;
`endif
    bus.step_valid = 1'b0;
    bus.next_count = 8'd255;
    bus.mazestate  = '1;
    bus.mazestate[145] = 1'b0;
    bus.mazestate[19]  = 1'b0;
    bus.begin_spot = 8'd145;
    bus.end_spot   = 8'd197;
    bus.game_pause = 1'b0;

    fork
      forever begin
        @(negedge CLK);
        if (mdl_valid) begin
          chk("count",       int'(bus.count),       int'(mdl.cnt));
          chk("lives",       int'(bus.lives),       int'(mdl.lives));
          chk("move_total",  int'(bus.move_total),  int'(mdl.moves));
          chk("game_state",  int'(bus.game_state),  int'(mdl.st));
          chk("won",         int'(bus.won),         int'(mdl.won));
          chk("crash_pulse", int'(bus.crash_pulse), int'(mdl.cp));
          chk("win_pulse",   int'(bus.win_pulse),   int'(mdl.wp));
        end
      end
    join_none

    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    chk("rst_count", int'(bus.count), 255);
    chk("rst_lives", int'(bus.lives), 3);
    chk("rst_state", int'(bus.game_state), 0);

    // Start on a wall cell is ignored
    step(8'd145);
    chk("wall_start_state", int'(bus.game_state), 0);

    bus.begin_spot = 8'd181;
    step(8'd181);
    chk("start_state", int'(bus.game_state), 1);
    chk("start_count", int'(bus.count), 181);
    step(8'd163);
    chk("move_count", int'(bus.count), 163);
    chk("move_total", int'(bus.move_total), exp_mv);
    step(8'd163);
    step(8'd100);
    chk("jump_count", int'(bus.count), 163);
    chk("jump_lives", int'(bus.lives), 3);

    // Paused strobe is discarded; same proposal crashes once released
    bus.game_pause = 1'b1;
    step(8'd255);
    chk("pause_count", int'(bus.count), 163);
    chk("pause_state", int'(bus.game_state), 1);
    bus.game_pause = 1'b0;
    step(8'd255);
    chk("crash1_state", int'(bus.game_state), 2);
    chk("crash1_lives", int'(bus.lives), 2);
    chk("crash1_pulse", int'(bus.crash_pulse), 1);
    repeat (9) step(8'd0);
    chk("hold9_state", int'(bus.game_state), 2);
    bus.game_pause = 1'b1;
    step(8'd0);
    bus.game_pause = 1'b0;
    chk("hold_pause_state", int'(bus.game_state), 2);
    step(8'd0);
    chk("hold10_state", int'(bus.game_state), 0);
    chk("idle_count", int'(bus.count), 255);

    step(8'd181);
    step(8'd163);
    step(8'd145);
    chk("crash2_lives", int'(bus.lives), 1);
    burst(10);
    chk("burst_state", int'(bus.game_state), 0);
    step(8'd181);
    step(8'd255);
    chk("over_state", int'(bus.game_state), 3);
    chk("over_won", int'(bus.won), 0);
    chk("over_lives", int'(bus.lives), 0);
    chk("over_count", int'(bus.count), 255);
    step(8'd181);
    chk("over_hold", int'(bus.game_state), 3);

    // Row wrap: column 17 cannot step right into the next row
    do_reset();
    bus.begin_spot = 8'd35;
    step(8'd35);
    step(8'd36);
    chk("wrap_count", int'(bus.count), 35);
    chk("wrap_lives", int'(bus.lives), 3);
    chk("wrap_pulse", int'(bus.crash_pulse), 0);
    step(8'd34);
    chk("left_count", int'(bus.count), 34);
    step(8'd35);
    step(8'd53);
    chk("down_count", int'(bus.count), 53);

    do_reset();
    bus.begin_spot = 8'd36;
    step(8'd36);
    step(8'd35);
    chk("lwrap_count", int'(bus.count), 36);

    // Win
    do_reset();
    bus.begin_spot = 8'd38;
    bus.end_spot   = 8'd20;
    step(8'd38);
    step(8'd20);
    chk("win_state", int'(bus.game_state), 3);
    chk("win_won", int'(bus.won), 1);
    chk("win_pulse", int'(bus.win_pulse), 1);
    chk("win_count", int'(bus.count), 20);
    step(8'd2);
    chk("win_hold_count", int'(bus.count), 20);
    chk("win_pulse_drop", int'(bus.win_pulse), 0);

    // Reset part-way through the crash hold
    do_reset();
    bus.begin_spot = 8'd181;
    step(8'd181);
    step(8'd163);
    step(8'd255);
    repeat (5) step(8'd0);
    chk("midcrash_state", int'(bus.game_state), 2);
    do_reset();
    chk("rst2_state", int'(bus.game_state), 0);
    chk("rst2_lives", int'(bus.lives), 3);
    chk("rst2_moves", int'(bus.move_total), 0);
    chk("rst2_count", int'(bus.count), 255);

    repeat (3) @(posedge CLK);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
